// File: rtl/wired_tlb_inv_ctrl.sv
// wired_tlb_inv_ctrl: INVTLB scan controller that walks every TLB entry and clears e on matches, yielding to external writes.
package wired_tlb_pkg;
  typedef struct packed {
    logic        e;
    logic        g;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic        huge_page;
  } tlb_key_t;
endpackage

module wired_tlb_inv_ctrl
  import wired_tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [4:0]    req_op_i,
  input  logic [9:0]    req_asid_i,
  input  logic [18:0]   req_vppn_i,
  output logic [IW-1:0] rd_idx_o,
  input  tlb_key_t      rd_key_i,
  input  logic          wr_valid_i,
  input  logic [IW-1:0] wr_idx_i,
  input  tlb_key_t      wr_key_i,
  output logic          upd_valid_o,
  output logic [IW-1:0] upd_idx_o,
  output tlb_key_t      upd_key_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [4:0] op;
  logic [9:0] asid;
  logic [18:0] vppn;
  logic err, am, va, opm, hit, last;
  tlb_key_t inv_key;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      err <= 1'b0;
      op <= '0;
      asid <= '0;
      vppn <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid_i) begin
        idx <= '0;
        op <= req_op_i;
        asid <= req_asid_i;
        vppn <= req_vppn_i;
        err <= req_op_i > 5'd6;
      end else if (state == SCAN && !wr_valid_i) begin
        idx <= idx + 1'b1;
      end
    end
  end
  always_comb begin
    am = rd_key_i.asid == asid;
    va = rd_key_i.vppn[18:9] == vppn[18:9] && (rd_key_i.huge_page || rd_key_i.vppn[8:0] == vppn[8:0]);
    opm = (op <= 5'd1) ? 1'b1 :
          (op == 5'd2) ? rd_key_i.g :
          (op == 5'd3) ? !rd_key_i.g :
          (op == 5'd4) ? !rd_key_i.g && am :
          (op == 5'd5) ? !rd_key_i.g && am && va :
          (op == 5'd6) ? (rd_key_i.g || am) && va : 1'b0;
    hit = state == SCAN && !wr_valid_i && rd_key_i.e && opm;
    last = idx == IW'(ENTRIES - 1);
    nxt = (state == IDLE) ? (req_valid_i ? (req_op_i <= 5'd6 ? SCAN : DONE) : IDLE) :
          (state == SCAN) ? (!wr_valid_i && last ? DONE : SCAN) : IDLE;
    inv_key = rd_key_i;
    inv_key.e = 1'b0;
  end
  // External writes win the update port unconditionally, even under reset
  assign upd_valid_o = wr_valid_i || hit;
  assign upd_idx_o = wr_valid_i ? wr_idx_i : idx;
  assign upd_key_o = wr_valid_i ? wr_key_i : inv_key;
  assign rd_idx_o = idx;
  assign req_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign err_o = state == DONE && err;
endmodule

// File: tb/tb_wired_tlb_inv_ctrl.sv
// tb_wired_tlb_inv_ctrl: randomized INVTLB requests with stalls and aborts, checked against an in-bench TLB reference.
module tb_wired_tlb_inv_ctrl;
  import wired_tlb_pkg::*;
  localparam int E = 32;
  localparam int IW = 5;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, wr_valid = 0, upd_valid, busy, done, err;
  logic [4:0] req_op = 0;
  logic [9:0] req_asid = 0;
  logic [18:0] req_vppn = 0;
  logic [IW-1:0] rd_idx, wr_idx = 0, upd_idx;
  tlb_key_t rd_key, wr_key = '0, upd_key;
  tlb_key_t mem [E];
  tlb_key_t ref_m [E];
  int n_cmp = 0, n_bad = 0;

  wired_tlb_inv_ctrl #(.ENTRIES(E)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_asid_i(req_asid), .req_vppn_i(req_vppn),
    .rd_idx_o(rd_idx), .rd_key_i(rd_key), .wr_valid_i(wr_valid), .wr_idx_i(wr_idx),
    .wr_key_i(wr_key), .upd_valid_o(upd_valid), .upd_idx_o(upd_idx), .upd_key_o(upd_key),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  assign rd_key = mem[rd_idx];
  always @(posedge clk) if (upd_valid) mem[upd_idx] <= upd_key;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_hit(tlb_key_t k, logic [4:0] op, logic [9:0] a, logic [18:0] v);
    bit am = k.asid == a;
    bit va = k.vppn[18:9] == v[18:9] && (k.huge_page || k.vppn[8:0] == v[8:0]);
    bit m;
    case (op)
      0, 1: m = 1;
      2: m = k.g;
      3: m = !k.g;
      4: m = !k.g && am;
      5: m = !k.g && am && va;
      6: m = (k.g || am) && va;
      default: m = 0;
    endcase
    return k.e && m;
  endfunction

  // Keys are drawn near the request operands so every op sees both hits and misses
  function automatic tlb_key_t rand_key(logic [9:0] a, logic [18:0] v);
    tlb_key_t k;
    k.e = ($urandom % 4) != 0;
    k.g = $urandom;
    k.asid = ($urandom % 2) ? a : 10'($urandom);
    case ($urandom % 3)
      0: k.vppn = v;
      1: k.vppn = {v[18:9], 9'($urandom)};
      default: k.vppn = 19'($urandom);
    endcase
    k.huge_page = $urandom;
    return k;
  endfunction

  task automatic compare_mem(input string tag);
    for (int i = 0; i < E; i++) chk($sformatf("%s_entry%0d", tag, i), mem[i], ref_m[i]);
  endtask

  task automatic run(input bit abort);
    logic [4:0] op;
    logic [9:0] a;
    logic [18:0] v;
    int nst [E];
    tlb_key_t x;
    bit h;
    op = ($urandom % 8 == 0) ? 5'(7 + $urandom % 25) : 5'($urandom % 7);
    if (abort) op = 5'($urandom % 7);
    a = 10'($urandom);
    v = 19'($urandom);
    for (int i = 0; i < E; i++) begin
      mem[i] = rand_key(a, v);
      nst[i] = ($urandom % 6 == 0) ? 1 + $urandom % 2 : 0;
    end
    ref_m = mem;
    @(posedge clk); #1;
    req_valid = 1; req_op = op; req_asid = a; req_vppn = v;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    req_valid = $urandom; req_op = 5'($urandom); req_asid = 10'($urandom); req_vppn = 19'($urandom);
    if (op <= 6) begin
      for (int p = 0; p < E; p++) begin
        for (int w = 0; w < nst[p]; w++) begin
          wr_valid = 1; wr_idx = IW'($urandom); wr_key = tlb_key_t'($urandom);
          @(negedge clk);
          chk("stall_upd_valid", upd_valid, 1);
          chk("stall_upd_idx", upd_idx, wr_idx);
          chk("stall_upd_key", upd_key, wr_key);
          chk("stall_rd_idx", rd_idx, p);
          chk("stall_busy", busy, 1);
          ref_m[wr_idx] = wr_key;
          @(posedge clk); #1;
          req_valid = $urandom;
        end
        wr_valid = 0;
        if (abort && p == 15) begin
          #1 rst = 1;
          wr_valid = 1; wr_idx = IW'($urandom); wr_key = tlb_key_t'($urandom);
          #1;
          chk("rst_ready", req_ready, 1);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_err", err, 0);
          chk("rst_rd_idx", rd_idx, 0);
          chk("rst_upd_valid", upd_valid, 1);
          chk("rst_upd_idx", upd_idx, wr_idx);
          ref_m[wr_idx] = wr_key;
          @(posedge clk); #1;
          wr_valid = 0; req_valid = 0;
          @(negedge clk);
          chk("rst_upd_quiet", upd_valid, 0);
          rst = 0;
          @(negedge clk);
          chk("post_rst_ready", req_ready, 1);
          chk("post_rst_done", done, 0);
          compare_mem("abort");
          return;
        end
        @(negedge clk);
        h = ref_hit(ref_m[p], op, a, v);
        chk("scan_rd_idx", rd_idx, p);
        chk("scan_upd_valid", upd_valid, h);
        chk("scan_done", done, 0);
        chk("scan_ready", req_ready, 0);
        if (h) begin
          x = ref_m[p];
          x.e = 0;
          chk("scan_upd_idx", upd_idx, p);
          chk("scan_upd_key", upd_key, x);
          ref_m[p] = x;
        end
        @(posedge clk); #1;
        req_valid = $urandom;
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_err", err, op > 6);
    chk("done_upd_valid", upd_valid, 0);
    chk("done_busy", busy, 1);
    chk("done_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk("after_done", done, 0);
    chk("after_ready", req_ready, 1);
    compare_mem("final");
  endtask

  initial begin
    for (int i = 0; i < E; i++) mem[i] = '0;
    #1;
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_rd_idx", rd_idx, 0);
    wr_valid = 1; wr_idx = 5'd9; wr_key = tlb_key_t'(32'h8000_1234);
    #1;
    chk("reset_upd_follow", upd_valid, 1);
    wr_valid = 0;
    #1;
    chk("reset_upd_idle", upd_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int t = 0; t < 80; t++) run(0);
    for (int t = 0; t < 4; t++) run(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 2000000");
    $fatal(1);
  end
endmodule
